fl_pipe_stat: RTL

Registered FrameLink output stage placed directly downstream of the FrameLink transformer. It accepts the transformer's TX stream, passes it through a two-entry skid buffer, and drives the next FrameLink consumer. The skid buffer cuts every forward and backward combinational path. The stage also checks frame-level protocol and can optionally collect frame and word statistics for the bench and for software.

---
 rtl/fl_pipe_stat.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fl_pipe_stat.sv
// fl_pipe_stat: registered FrameLink output stage with a two-entry skid buffer,
// a frame protocol checker (ERR) and optional saturating frame/word counters.
// Ports: CLK, RESET (sync, active-low), RX_* FrameLink input, TX_* FrameLink
// output, ERR[1:0] sticky errors, CNT_CLEAR, FRAME_CNT/WORD_CNT (32-bit).
// Build option: define FL_PIPE_STAT_STATS_EN to build the counters; otherwise
// FRAME_CNT and WORD_CNT are tied to 0.
module fl_pipe_stat #(
  parameter int DATA_WIDTH = 32,
  parameter int DREM_WIDTH = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [DREM_WIDTH-1:0] RX_DREM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [DREM_WIDTH-1:0] TX_DREM,
  output logic                  TX_SOF_N,
  output logic                  TX_EOF_N,
  output logic                  TX_SOP_N,
  output logic                  TX_EOP_N,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [1:0]            ERR,
  input  logic                  CNT_CLEAR,
  output logic [31:0]           FRAME_CNT,
  output logic [31:0]           WORD_CNT
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DREM_WIDTH-1:0] drem;
    logic                  sof_n;
    logic                  eof_n;
    logic                  sop_n;
    logic                  eop_n;
  } word_t;

  localparam word_t IDLE_W = '{'0, '0, 1'b1, 1'b1, 1'b1, 1'b1};

  word_t rx_w;
  word_t main_q;
  word_t skid_q;
  logic  main_v;
  logic  skid_v;
  logic  skid_v_nxt;
  logic  rdy_n_q;
  logic  rx_xfer;
  logic  tx_xfer;

  assign rx_w = '{RX_DATA, RX_DREM, RX_SOF_N,
                  RX_EOF_N, RX_SOP_N, RX_EOP_N};

  assign rx_xfer = ~RX_SRC_RDY_N & ~rdy_n_q;
  assign tx_xfer = main_v & ~TX_DST_RDY_N;

  // skid can only be written while it is empty,
  // because RX is held off whenever it is full
  always_comb begin
    skid_v_nxt = skid_v;
    if (skid_v)
      skid_v_nxt = ~tx_xfer;
    else
      skid_v_nxt = rx_xfer & main_v & ~tx_xfer;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      main_q  <= IDLE_W;
      skid_q  <= IDLE_W;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      rdy_n_q <= 1'b1;
    end else begin
      if (skid_v) begin
        if (tx_xfer)
          main_q <= skid_q;
      end else if (rx_xfer) begin
        if (!main_v || tx_xfer) begin
          main_q <= rx_w;
          main_v <= 1'b1;
        end else begin
          skid_q <= rx_w;
        end
      end else if (tx_xfer) begin
        main_v <= 1'b0;
      end
      skid_v  <= skid_v_nxt;
      rdy_n_q <= skid_v_nxt;
    end
  end

  assign RX_DST_RDY_N = rdy_n_q;
  assign TX_SRC_RDY_N = ~main_v;
  assign TX_DATA      = main_q.data;
  assign TX_DREM      = main_q.drem;
  assign TX_SOF_N     = main_q.sof_n;
  assign TX_EOF_N     = main_q.eof_n;
  assign TX_SOP_N     = main_q.sop_n;
  assign TX_EOP_N     = main_q.eop_n;

  logic       in_frame;
  logic [1:0] err_q;
  logic [1:0] err_hit;
  logic       sof;
  logic       eof;
  logic       eop;

  assign sof = ~RX_SOF_N;
  assign eof = ~RX_EOF_N;
  assign eop = ~RX_EOP_N;

  assign err_hit[0] = sof & in_frame;
  assign err_hit[1] = (~sof & ~in_frame) | (eof & ~eop);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      in_frame <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      if (rx_xfer) begin
        if (eof)
          in_frame <= 1'b0;
        else if (sof)
          in_frame <= 1'b1;
      end
      if (CNT_CLEAR)
        err_q <= 2'b00;
      else if (rx_xfer)
        err_q <= err_q | err_hit;
    end
  end

  assign ERR = err_q;

`ifdef FL_PIPE_STAT_STATS_EN
  logic [31:0] frame_q;
  logic [31:0] word_q;

  always_ff @(posedge CLK) begin
    if (!RESET || CNT_CLEAR) begin
      frame_q <= '0;
      word_q  <= '0;
    end else if (tx_xfer) begin
      if (word_q != 32'hFFFF_FFFF)
        word_q <= word_q + 32'd1;
      if (!main_q.eof_n && frame_q != 32'hFFFF_FFFF)
        frame_q <= frame_q + 32'd1;
    end
  end

  assign FRAME_CNT = frame_q;
  assign WORD_CNT  = word_q;
`else
  assign FRAME_CNT = 32'd0;
  assign WORD_CNT  = 32'd0;
`endif

endmodule
